// File: rtl/brg_vvadd_xcel_ctrl.sv
// brg_vvadd_xcel_ctrl: CSR-programmed sequencer for the VVADD accelerator (C[i] = A[i] + B[i]).
// Defining BRG_VVADD_XCEL_CTRL_PERF_EN adds the CYCLES (CSR 6) and STALLS (CSR 7) counters.
module brg_vvadd_xcel_ctrl #(
   parameter int data_width_p = 32,
   parameter int addr_width_p = 28,
   parameter int len_width_p  = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    csr_v_i,
   input  logic                    csr_we_i,
   input  logic [3:0]              csr_idx_i,
   input  logic [data_width_p-1:0] csr_wdata_i,
   output logic                    csr_yumi_o,
   output logic [data_width_p-1:0] csr_rdata_o,
   output logic                    csr_rdata_v_o,
   output logic                    req_v_o,
   output logic                    req_we_o,
   output logic [addr_width_p-1:0] req_addr_o,
   output logic [data_width_p-1:0] req_data_o,
   input  logic                    req_ready_i,
   input  logic                    resp_v_i,
   input  logic [data_width_p-1:0] resp_data_i,
   output logic                    busy_o,
   output logic [2:0]              state_dbg_o
);

   // Handshake: a request transfers on a rising edge with req_v_o & req_ready_i; until then
   // req_we_o/req_addr_o/req_data_o hold steady. CSR accesses and load responses have no back-pressure.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE_A = 3'd1,
      S_ISSUE_B = 3'd2,
      S_WAIT    = 3'd3,
      S_STORE   = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [data_width_p-1:0] a_base_q, b_base_q, c_base_q, op_a_q, op_b_q, rdata_d;
   logic [len_width_p-1:0]  len_q, i_q, i_inc;
   logic [addr_width_p-1:0] offset;
   logic [1:0]              resp_cnt_q;
   logic                    done_q, csr_wr, go, cfg_wr, store_fire, last_elem;
   logic                    resp_take, done_set, done_clr;

   assign csr_yumi_o  = csr_v_i;
   assign state_dbg_o = state_q;
   assign csr_wr      = csr_v_i & csr_we_i;
   assign go          = csr_wr && (csr_idx_i == 4'd4) && csr_wdata_i[0] && (state_q == S_IDLE);
   assign cfg_wr      = csr_wr && (state_q == S_IDLE);
   assign i_inc       = i_q + len_width_p'(1);
   assign last_elem   = (i_inc == len_q);
   assign store_fire  = (state_q == S_STORE) && req_ready_i;
   assign offset      = addr_width_p'(i_q) << 2;
   // Responses only belong to ISSUE_B/WAIT, and at most two per element; anything else is dropped.
   assign resp_take   = resp_v_i && ((state_q == S_ISSUE_B) || (state_q == S_WAIT)) &&
                        (resp_cnt_q != 2'd2);
   assign done_set    = (go && (len_q == '0)) || (store_fire && last_elem);
   assign done_clr    = go || (csr_wr && (csr_idx_i == 4'd5) && csr_wdata_i[0]);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (go && (len_q != '0)) state_d = S_ISSUE_A;
         S_ISSUE_A: if (req_ready_i) state_d = S_ISSUE_B;
         S_ISSUE_B: if (req_ready_i) state_d = S_WAIT;
         S_WAIT:    if (resp_cnt_q == 2'd2) state_d = S_STORE;
         S_STORE:   if (req_ready_i) state_d = last_elem ? S_IDLE : S_ISSUE_A;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_v_o    = 1'b0;
      req_we_o   = 1'b0;
      req_addr_o = '0;
      req_data_o = '0;
      busy_o     = (state_q != S_IDLE);
      case (state_q)
         S_ISSUE_A: begin
            req_v_o    = 1'b1;
            req_addr_o = addr_width_p'(a_base_q) + offset;
         end
         S_ISSUE_B: begin
            req_v_o    = 1'b1;
            req_addr_o = addr_width_p'(b_base_q) + offset;
         end
         S_STORE: begin
            req_v_o    = 1'b1;
            req_we_o   = 1'b1;
            req_addr_o = addr_width_p'(c_base_q) + offset;
            req_data_o = op_a_q + op_b_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         a_base_q <= '0;
         b_base_q <= '0;
         c_base_q <= '0;
         len_q    <= '0;
      end else if (cfg_wr) begin
         case (csr_idx_i)
            4'd0:    a_base_q <= csr_wdata_i;
            4'd1:    b_base_q <= csr_wdata_i;
            4'd2:    c_base_q <= csr_wdata_i;
            4'd3:    len_q    <= csr_wdata_i[len_width_p-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         i_q        <= '0;
         resp_cnt_q <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         if (go)              i_q <= '0;
         else if (store_fire) i_q <= i_inc;
         if (store_fire)     resp_cnt_q <= '0;
         else if (resp_take) resp_cnt_q <= resp_cnt_q + 2'd1;
         if (resp_take && (resp_cnt_q == 2'd0)) op_a_q <= resp_data_i;
         if (resp_take && (resp_cnt_q == 2'd1)) op_b_q <= resp_data_i;
         // A done-set event outranks a same-cycle clear from software.
         if (done_set)      done_q <= 1'b1;
         else if (done_clr) done_q <= 1'b0;
      end
   end

`ifdef BRG_VVADD_XCEL_CTRL_PERF_EN
   logic [data_width_p-1:0] cycles_q, stalls_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cycles_q <= '0;
         stalls_q <= '0;
      end else if (go) begin
         cycles_q <= '0;
         stalls_q <= '0;
      end else begin
         if (busy_o && (cycles_q != '1)) cycles_q <= cycles_q + 1'b1;
         if (req_v_o && !req_ready_i && (stalls_q != '1)) stalls_q <= stalls_q + 1'b1;
      end
   end
`endif

   always_comb begin
      rdata_d = '0;
      case (csr_idx_i)
         4'd0:    rdata_d = a_base_q;
         4'd1:    rdata_d = b_base_q;
         4'd2:    rdata_d = c_base_q;
         4'd3:    rdata_d = data_width_p'(len_q);
         4'd5:    rdata_d = {{(data_width_p-2){1'b0}}, busy_o, done_q};
`ifdef BRG_VVADD_XCEL_CTRL_PERF_EN
         4'd6:    rdata_d = cycles_q;
         4'd7:    rdata_d = stalls_q;
`endif
         default: rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         csr_rdata_v_o <= 1'b0;
         csr_rdata_o   <= '0;
      end else begin
         csr_rdata_v_o <= csr_v_i;
         csr_rdata_o   <= (csr_v_i && !csr_we_i) ? rdata_d : '0;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (reset_n_i && resp_v_i && !resp_take)
         $error("brg_vvadd_xcel_ctrl: unexpected load response in state %0d", state_q);
   end
`endif

endmodule
